spi_xfer_arbiter: RTL and testbench
===================================

// Module: spi_xfer_arbiter
// PURPOSE
//  Shares one SPI_Master_With_Single_CS (4 bytes per CS) among N_REQ requesters.
//  Examples: init sequencer, UART command path, periodic status poller.
//  Arbitration is round-robin. The winner's 32-bit frame is latched and fed
//  byte-serially to the master; the 4 returned MISO bytes come back as one
//  32-bit word with a one-cycle done pulse to that requester.
// PARAMETERS
//  N_REQ        3    number of requesters, 2..8; req[0] wins the first grant after reset
//  TIMEOUT_CLKS 4096 per-byte watchdog limit in clk40M cycles (SPI_ARB_TIMEOUT_EN only)
// PORTS
//  clk40M       in   1        system clock, 40 MHz
//  nRst         in   1        reset, asynchronous, active-low
//  req          in   N_REQ    transfer request, one bit per requester, level
//  req_frame    in   N_REQ*32 frame for requester i is [32i+31:32i]; byte0 = [7:0] is sent first
//  gnt          out  N_REQ    one-cycle pulse: frame of requester i accepted
//  done         out  N_REQ    one-cycle pulse: transfer of requester i finished
//  rx_frame     out  32       MISO bytes of the last transfer; byte0 is in [7:0]
//  busy         out  1        high from grant until done/err
//  err          out  1        one-cycle pulse on watchdog abort; always 0 without the macro
//  m_tx_byte    out  8        to master i_TX_Byte
//  m_tx_dv      out  1        to master i_TX_DV
//  m_tx_ready   in   1        from master o_TX_Ready
//  m_rx_dv      in   1        from master o_RX_DV
//  m_rx_byte    in   8        from master o_RX_Byte
// BEHAVIOUR
//  Reset values: all outputs 0. rr pointer = 0. State = IDLE. Byte index = 0.
//  Master i_TX_Count is tied to 4 outside this block.
//  Registered outputs: gnt, done, err, busy, rx_frame, m_tx_dv, m_tx_byte.
//  rdy_rise = m_tx_ready & ~m_tx_ready_q, where m_tx_ready_q is a 1-cycle delay.
//  FSM transitions:
//   IDLE: if (|req) and m_tx_ready:
//    - pick the first set req bit, searching upward from rr with wrap
//    - latch its frame; pulse gnt[w]; set busy; rr <= w+1 mod N_REQ
//    - go to ISSUE
//   ISSUE: m_tx_dv=1 for exactly one cycle; m_tx_byte = frame byte[idx]; go to WAIT.
//   WAIT, on rdy_rise:
//    - idx<3: idx++, go to ISSUE
//    - idx==3: go to DONE
//   DONE: done[w] pulses 1 cycle; busy<=0; idx<=0; go to IDLE.
//  RX capture: each m_rx_dv writes m_rx_byte into rx_frame byte[rx_idx], then rx_idx++.
//   rx_idx is cleared at grant. rx_frame is stable from the done pulse until the next grant.
//  Latency: req high with master idle -> gnt on the next edge -> first m_tx_dv one cycle later.
//  Back-to-back grants: at least 1 IDLE cycle between done and the next gnt.
//  Requester handshake:
//   - hold req and frame until gnt
//   - req is re-sampled only in IDLE, so a req left high after gnt requests a new transfer
//  Simultaneous events:
//   - a req rising during a transfer waits; no preemption
//   - all req high: grants rotate 0,1,2,0...
//   - req dropped before gnt: withdrawn, no gnt
//  m_tx_ready low in IDLE: no grant is issued.
//  nRst low mid-transfer: immediate return to reset values; no done pulse.
//   The master's own reset is the same nRst.
// CONFIGURATION
//  SPI_ARB_TIMEOUT_EN defined:
//   - WAIT counts clocks; the counter clears on each ISSUE
//   - reaching TIMEOUT_CLKS with no rdy_rise:
//       pulse err; skip done; clear busy; idx<=0; go to IDLE; rr is still advanced
//  SPI_ARB_TIMEOUT_EN undefined:
//   - no counter; WAIT has no exit other than rdy_rise; err tied to 0
// TESTING
//  1. Single request:
//     - stimulus: req=001, frame0=0xC007_00F9
//     - response: gnt=001; tx bytes F9,00,07,C0 in order; done=001; rx_frame = MISO model bytes
//  2. Round-robin:
//     - stimulus: req=111 held through 6 transfers
//     - response: gnt sequence 001,010,100,001,010,100; exactly one done per gnt
//  3. Late request:
//     - stimulus: req[0] active, req[2] rises during its byte 2
//     - response: req[2] granted only after done[0] plus 1 IDLE cycle; req[0] frame not corrupted
//  4. Reset mid-transfer:
//     - stimulus: nRst low after the 2nd m_tx_dv
//     - response: gnt/done/busy/m_tx_dv all 0; after release, req=010 is served from byte0
//  5. Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT_CLKS=64):
//     - stimulus: master model holds m_tx_ready low
//     - response: err pulses exactly 64 clocks after the first m_tx_dv; no done; busy=0
//  6. Master not ready:
//     - stimulus: m_tx_ready=0 in IDLE with req=001
//     - response: no gnt until m_tx_ready=1; then gnt on the next edge

Source files
------------

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one 4-byte SPI master among N_REQ requesters.
// Optional per-byte watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_xfer_arbiter #(
  parameter int unsigned N_REQ        = 3
`ifdef SPI_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CLKS = 4096
`endif
) (
  input  logic                 clk40M,
  input  logic                 nRst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*32-1:0]  req_frame,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic [31:0]          rx_frame,
  output logic                 busy,
  output logic                 err,
  output logic [7:0]           m_tx_byte,
  output logic                 m_tx_dv,
  input  logic                 m_tx_ready,
  input  logic                 m_rx_dv,
  input  logic [7:0]           m_rx_byte
);

  localparam int unsigned RW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [RW-1:0] rr;
  logic [RW-1:0] win_q;
  logic [RW-1:0] pick;
  logic [RW-1:0] cidx;
  logic          pick_vld;
  logic [1:0]    idx;
  logic [1:0]    rx_idx;
  logic [31:0]   frame_q;
  logic          m_tx_ready_q;
  logic          rdy_rise;
  int unsigned   cand;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [31:0]   wd_cnt;
`endif

  assign rdy_rise = m_tx_ready & ~m_tx_ready_q;

  // First requester at or above rr, wrapping modulo N_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = 0;
    cidx     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = 32'(rr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cidx = RW'(cand);
      if (!pick_vld && req[cidx]) begin
        pick_vld = 1'b1;
        pick     = cidx;
      end
    end
  end

`ifndef SPI_ARB_TIMEOUT_EN
  assign err = 1'b0;
`endif

  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      state        <= S_IDLE;
      rr           <= '0;
      win_q        <= '0;
      idx          <= '0;
      rx_idx       <= '0;
      frame_q      <= '0;
      m_tx_ready_q <= 1'b0;
      gnt          <= '0;
      done         <= '0;
      busy         <= 1'b0;
      rx_frame     <= '0;
      m_tx_dv      <= 1'b0;
      m_tx_byte    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      err          <= 1'b0;
      wd_cnt       <= '0;
`endif
    end else begin
      gnt          <= '0;
      done         <= '0;
      m_tx_dv      <= 1'b0;
      m_tx_ready_q <= m_tx_ready;
`ifdef SPI_ARB_TIMEOUT_EN
      err          <= 1'b0;
`endif
      // Capture is gated by busy so rx_frame holds from done until the next grant.
      if (busy && m_rx_dv) begin
        rx_frame[8*rx_idx +: 8] <= m_rx_byte;
        rx_idx                  <= rx_idx + 2'd1;
      end

      case (state)
        S_IDLE: begin
          if (pick_vld && m_tx_ready) begin
            frame_q   <= req_frame[32*pick +: 32];
            win_q     <= pick;
            gnt[pick] <= 1'b1;
            busy      <= 1'b1;
            rx_idx    <= '0;
            idx       <= '0;
            rr        <= (pick == RW'(N_REQ - 1)) ? '0 : pick + RW'(1);
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          m_tx_dv   <= 1'b1;
          m_tx_byte <= frame_q[8*idx +: 8];
`ifdef SPI_ARB_TIMEOUT_EN
          wd_cnt    <= '0;
`endif
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (rdy_rise) begin
            if (idx == 2'd3) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 2'd1;
              state <= S_ISSUE;
            end
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (wd_cnt == TIMEOUT_CLKS - 1) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            idx   <= '0;
            state <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
`endif
        end
        S_DONE: begin
          done[win_q] <= 1'b1;
          busy        <= 1'b0;
          idx         <= '0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with a behavioural SPI master that
// answers each byte with MISO = MOSI ^ 8'h5A.
module tb_spi_xfer_arbiter;

  logic        clk40M = 1'b0;
  logic        nRst;
  logic [2:0]  req;
  logic [95:0] req_frame;
  logic [2:0]  gnt, done;
  logic [31:0] rx_frame;
  logic        busy, err;
  logic [7:0]  m_tx_byte;
  logic        m_tx_dv;
  logic        m_tx_ready;
  logic        m_rx_dv;
  logic [7:0]  m_rx_byte;

  logic        mdl_rdy;
  logic [7:0]  mdl_b;
  int          mdl_cnt;
  logic        hold_lo;
  logic        stall;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] tx_log[$];
  int n_gnt = 0, n_done = 0, n_errp = 0;

  spi_xfer_arbiter #(
    .N_REQ(3)
`ifdef SPI_ARB_TIMEOUT_EN
    , .TIMEOUT_CLKS(64)
`endif
  ) dut (
    .clk40M(clk40M), .nRst(nRst), .req(req), .req_frame(req_frame),
    .gnt(gnt), .done(done), .rx_frame(rx_frame), .busy(busy), .err(err),
    .m_tx_byte(m_tx_byte), .m_tx_dv(m_tx_dv), .m_tx_ready(m_tx_ready),
    .m_rx_dv(m_rx_dv), .m_rx_byte(m_rx_byte)
  );

  always #5 clk40M = ~clk40M;

  assign m_tx_ready = mdl_rdy & ~hold_lo;

  // Master model: ready drops after a byte is taken, RX byte then ready rise.
  always @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      mdl_rdy   <= 1'b1;
      m_rx_dv   <= 1'b0;
      m_rx_byte <= 8'h00;
      mdl_b     <= 8'h00;
      mdl_cnt   <= 0;
    end else begin
      m_rx_dv <= 1'b0;
      if (m_tx_dv && mdl_rdy) begin
        mdl_rdy <= 1'b0;
        mdl_b   <= m_tx_byte;
        mdl_cnt <= 6;
      end else if (!mdl_rdy && !stall) begin
        if (mdl_cnt == 2) begin
          m_rx_dv   <= 1'b1;
          m_rx_byte <= mdl_b ^ 8'h5A;
        end
        if (mdl_cnt == 0) mdl_rdy <= 1'b1;
        else mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  always @(negedge clk40M) begin
    if (m_tx_dv) tx_log.push_back(m_tx_byte);
    if (|gnt)    n_gnt++;
    if (|done)   n_done++;
    if (err)     n_errp++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk40M);
    #1;
  endtask

  task automatic wait_gnt(input string tag, input logic [2:0] exp);
    for (int k = 0; k < 50; k++) begin
      tick();
      if (|gnt) break;
    end
    check(tag, 32'(gnt), 32'(exp));
  endtask

  task automatic wait_done(input string tag, input logic [2:0] exp);
    for (int k = 0; k < 400; k++) begin
      tick();
      if (|done || err) break;
    end
    check(tag, 32'(done), 32'(exp));
  endtask

  task automatic wait_tx(input int target);
    for (int k = 0; k < 200; k++) begin
      if (tx_log.size() >= target) break;
      tick();
    end
  endtask

  task automatic xfer_check(input string tag, input int base, input logic [31:0] frame);
    logic [31:0] txw;
    txw = '0;
    for (int i = 0; i < 4; i++)
      if (base + i < tx_log.size()) txw[8*i +: 8] = tx_log[base + i];
    check({tag, "_tx"}, txw, frame);
    check({tag, "_ntx"}, 32'(tx_log.size() - base), 32'd4);
    check({tag, "_rx"}, rx_frame, frame ^ 32'h5A5A5A5A);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, g0, d0, n;
    nRst = 1'b0; req = '0; req_frame = '0; hold_lo = 1'b0; stall = 1'b0;
    repeat (3) tick();
    check("rst_gnt",  32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dv",   32'(m_tx_dv), 32'd0);
    check("rst_byte", 32'(m_tx_byte), 32'd0);
    check("rst_rx",   rx_frame, 32'd0);
    check("rst_err",  32'(err), 32'd0);
    nRst = 1'b1;
    tick();

    // Single request and first-byte latency
    req_frame[31:0] = 32'hC007_00F9;
    base = tx_log.size();
    req = 3'b001;
    wait_gnt("t1_gnt", 3'b001);
    check("t1_busy", 32'(busy), 32'd1);
    req = 3'b000;
    tick();
    check("t1_dv", 32'(m_tx_dv), 32'd1);
    check("t1_b0", 32'(m_tx_byte), 32'hF9);
    wait_done("t1_done", 3'b001);
    check("t1_busy_off", 32'(busy), 32'd0);
    xfer_check("t1", base, 32'hC007_00F9);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);

    // Round robin from a fresh pointer
    nRst = 1'b0; tick(); nRst = 1'b1; tick();
    req_frame = {32'h33CC_0F12, 32'h22BB_A0E1, 32'h11AA_5C3D};
    g0 = n_gnt;
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      base = tx_log.size();
      wait_gnt($sformatf("t2_gnt%0d", k), 3'b001 << (k % 3));
      if (k == 5) req = 3'b000;
      wait_done($sformatf("t2_done%0d", k), 3'b001 << (k % 3));
      xfer_check($sformatf("t2_%0d", k), base, req_frame[32*(k % 3) +: 32]);
    end
    repeat (3) tick();
    check("t2_ngnt", 32'(n_gnt - g0), 32'd6);

    // Late request waits for done plus one idle cycle
    req_frame[31:0] = 32'hA1B2_C3D4;
    base = tx_log.size();
    req = 3'b001;
    wait_gnt("t3_gnt0", 3'b001);
    req = 3'b000;
    req_frame[31:0] = 32'hDEAD_BEEF;
    wait_tx(base + 3);
    req_frame[95:64] = 32'h0BAD_F00D;
    req = 3'b100;
    g0 = n_gnt;
    wait_done("t3_done0", 3'b001);
    check("t3_gnt_held", 32'(gnt), 32'd0);
    check("t3_ngnt", 32'(n_gnt - g0), 32'd0);
    xfer_check("t3a", base, 32'hA1B2_C3D4);
    base = tx_log.size();
    tick();
    check("t3_gnt2", 32'(gnt), 32'b100);
    req = 3'b000;
    wait_done("t3_done2", 3'b100);
    xfer_check("t3b", base, 32'h0BAD_F00D);

    // Reset in the middle of a transfer
    req_frame[31:0] = 32'h1357_9BDF;
    base = tx_log.size();
    req = 3'b001;
    wait_gnt("t4_gnt0", 3'b001);
    req = 3'b000;
    wait_tx(base + 2);
    nRst = 1'b0;
    #1;
    check("t4_rst_gnt",  32'(gnt), 32'd0);
    check("t4_rst_done", 32'(done), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_dv",   32'(m_tx_dv), 32'd0);
    d0 = n_done;
    tick();
    nRst = 1'b1;
    req_frame[63:32] = 32'h5566_7788;
    req = 3'b010;
    base = tx_log.size();
    wait_gnt("t4_gnt1", 3'b010);
    req = 3'b000;
    wait_done("t4_done", 3'b010);
    xfer_check("t4", base, 32'h5566_7788);
    check("t4_ndone", 32'(n_done - d0), 32'd1);

    // Master not ready in IDLE blocks the grant
    hold_lo = 1'b1;
    req_frame[31:0] = 32'h2468_ACE0;
    g0 = n_gnt;
    req = 3'b001;
    repeat (6) tick();
    check("t6_nogrant", 32'(n_gnt - g0), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    hold_lo = 1'b0;
    base = tx_log.size();
    tick();
    check("t6_gnt", 32'(gnt), 32'b001);
    req = 3'b000;
    wait_done("t6_done", 3'b001);
    xfer_check("t6", base, 32'h2468_ACE0);

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog abort with the master stuck
    stall = 1'b1;
    req_frame[63:32] = 32'h0F0F_0F0F;
    d0 = n_done;
    req = 3'b010;
    wait_gnt("t5_gnt", 3'b010);
    req = 3'b000;
    tick();
    check("t5_dv", 32'(m_tx_dv), 32'd1);
    n = 0;
    while (!err && n < 200) begin
      tick();
      n++;
    end
    check("t5_err_lat", 32'(n), 32'd64);
    check("t5_busy", 32'(busy), 32'd0);
    tick();
    check("t5_err_pulse", 32'(err), 32'd0);
    check("t5_nodone", 32'(n_done - d0), 32'd0);
    stall = 1'b0;
    repeat (20) tick();
`else
    repeat (5) tick();
    check("err_never", 32'(n_errp), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
